// File: rtl/ion_packet_collector_pkg.sv
// rtl/ion_packet_collector_pkg.sv - shared constants, state encoding and channel encoder for the ion packet collector
package ion_packet_collector_pkg;

    localparam int DATA_W     = 110;
    localparam int CHANNELS   = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int CHAN_W     = 3;
    localparam int ENTRY_W    = DATA_W + CHAN_W;
    localparam int NB         = (DATA_W + 7) / 8;
    localparam int SHIFT_W    = NB * 8;

    localparam logic [3:0] HEADER_TAG = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    // Lowest set strobe wins; scanning downward lets the lowest index overwrite.
    function automatic logic [CHAN_W-1:0] lowest_chan(input logic [CHANNELS-1:0] strobes);
        logic [CHAN_W-1:0] idx;
        idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (strobes[i]) idx = CHAN_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/packet_fifo.sv
// rtl/packet_fifo.sv - synchronous show-ahead FIFO holding captured packet entries
module packet_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Fullness is judged on the count at the start of the cycle, so a
    // simultaneous pop never makes room for the push.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ion_packet_collector.sv
// rtl/ion_packet_collector.sv - captures strobed sensor packets and serializes them as 15-byte frames
module ion_packet_collector
    import ion_packet_collector_pkg::*;
(
    input  logic                clock,
    input  logic                resetn,
    input  logic [CHANNELS-1:0] ready_in,
    input  logic [DATA_W-1:0]   data_in,
    output logic [7:0]          out_byte,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic [7:0]          drop_count
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [3:0] LAST_BYTE = 4'(NB - 1);

    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head;
    logic               strobe;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    state_t             state;
    logic [SHIFT_W-1:0] shift;
    logic [3:0]         byte_cnt;

    assign strobe    = |ready_in;
    assign push_data = {lowest_chan(ready_in), data_in};
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

    packet_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (strobe),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            drop_count <= '0;
        end else if (strobe && fifo_full && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    // out_byte always holds the byte being offered, so it is preloaded one
    // step ahead of each accept from the top of the shift register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_byte  <= '0;
            shift     <= '0;
            byte_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shift     <= {{(SHIFT_W - DATA_W){1'b0}}, head[DATA_W-1:0]};
                        out_byte  <= {HEADER_TAG, 1'b0, head[ENTRY_W-1 -: CHAN_W]};
                        out_valid <= 1'b1;
                        state     <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (out_ready) begin
                        out_byte <= shift[SHIFT_W-1 -: 8];
                        byte_cnt <= '0;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (out_ready) begin
                        shift    <= shift << 8;
                        byte_cnt <= byte_cnt + 4'd1;
                        if (byte_cnt == LAST_BYTE) begin
                            out_valid <= 1'b0;
                            out_byte  <= '0;
                            state     <= ST_IDLE;
                        end else begin
                            out_byte <= shift[SHIFT_W-9 -: 8];
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ion_packet_collector.sv
// tb/tb_ion_packet_collector.sv - directed self-checking bench for ion_packet_collector
module tb_ion_packet_collector;

    logic         clock;
    logic         resetn;
    logic [7:0]   ready_in;
    logic [109:0] data_in;
    logic [7:0]   out_byte;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic [7:0]   drop_count;

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte  = 8'h00;

    typedef struct {
        logic [7:0]   ready;
        logic [109:0] data;
        logic [7:0]   hdr;
        logic [7:0]   b1;
        logic [7:0]   b14;
    } vec_t;

    vec_t vt[4];

    ion_packet_collector dut (
        .clock      (clock),
        .resetn     (resetn),
        .ready_in   (ready_in),
        .data_in    (data_in),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .drop_count (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [109:0] d, input int i);
        logic [111:0] s;
        s = {2'b00, d};
        s = s << (8 * (i - 1));
        return s[111:104];
    endfunction

    always @(negedge clock) begin
        if (resetn && out_valid && out_ready) q.push_back(out_byte);
    end

    // A stalled byte must be offered unchanged on the next cycle.
    always @(negedge clock) begin
        if (resetn && prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_byte", 32'(out_byte), 32'(prev_byte));
        end
        prev_stall = resetn && out_valid && !out_ready;
        prev_byte  = out_byte;
    end

    task automatic strobe(input logic [7:0] r, input logic [109:0] d);
        ready_in = r;
        data_in  = d;
        @(posedge clock);
        #1;
        ready_in = 8'h00;
    endtask

    task automatic wait_bytes(input int n, input bit rnd);
        int cyc = 0;
        while (q.size() < n && cyc < 2000) begin
            @(posedge clock);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            cyc++;
        end
        chk("wait_bytes", 32'(q.size() >= n), 32'd1);
        out_ready = 1'b1;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (busy && cyc < 200) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        chk("wait_idle", 32'(busy), 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic chk_frame(input string name, input int base, input logic [7:0] hdr, input logic [109:0] d);
        chk({name, "_hdr"}, 32'(q[base]), 32'(hdr));
        for (int i = 1; i <= 14; i++) chk({name, "_byte"}, 32'(q[base + i]), 32'(model_byte(d, i)));
    endtask

    initial begin
        logic [109:0] da;
        logic [109:0] db;
        int hi;

        vt[0] = '{8'b0000_0100, 110'h1, 8'hA2, 8'h00, 8'h01};
        vt[1] = '{8'h01, {110{1'b1}}, 8'hA0, 8'h3F, 8'hFF};
        vt[2] = '{8'b0001_0100, 110'h123456789ABCDEF, 8'hA2, 8'h00, 8'hEF};
        vt[3] = '{8'h80, {6'h2A, 96'h0, 8'hC3}, 8'hA7, 8'h2A, 8'hC3};

        resetn    = 1'b0;
        ready_in  = 8'h00;
        data_in   = '0;
        out_ready = 1'b1;
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_byte", 32'(out_byte), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b1;
        @(posedge clock);
        #1;

        for (int v = 0; v < 4; v++) begin
            q.delete();
            strobe(vt[v].ready, vt[v].data);
            @(negedge clock);
            chk("lat_pre_valid", 32'(out_valid), 32'd0);
            chk("lat_pre_busy", 32'(busy), 32'd1);
            hi = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clock);
                if (out_valid) hi++;
                else break;
            end
            chk("valid_run", 32'(hi), 32'd15);
            chk("busy_fall", 32'(busy), 32'd0);
            @(posedge clock);
            #1;
            wait_idle();
            chk("frame_len", 32'(q.size()), 32'd15);
            chk("tbl_hdr", 32'(q[0]), 32'(vt[v].hdr));
            chk("tbl_b1", 32'(q[1]), 32'(vt[v].b1));
            chk("tbl_b14", 32'(q[14]), 32'(vt[v].b14));
            chk_frame("tbl", 0, vt[v].hdr, vt[v].data);
            chk("tbl_drop", 32'(drop_count), 32'd0);
        end

        q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) strobe(8'(1 << i), 110'(i + 1));
        @(negedge clock);
        chk("ovf_drop", 32'(drop_count), 32'd1);
        chk("ovf_valid", 32'(out_valid), 32'd1);
        chk("ovf_byte", 32'(out_byte), 32'hA0);
        chk("ovf_busy", 32'(busy), 32'd1);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        wait_bytes(75, 1'b0);
        wait_idle();
        chk("ovf_len", 32'(q.size()), 32'd75);
        for (int k = 0; k < 5; k++) chk_frame("ovf", 15 * k, 8'(8'hA0 + k), 110'(k + 1));
        chk("ovf_drop_end", 32'(drop_count), 32'd1);

        q.delete();
        da = {6'h15, 24'hC0FFEE, 80'h0123456789ABCDEF0011};
        db = {6'h3C, 40'hDEADBEEF55, 64'hFEDCBA9876543210};
        strobe(8'h08, da);
        strobe(8'h40, db);
        wait_bytes(30, 1'b1);
        wait_idle();
        chk("bp_len", 32'(q.size()), 32'd30);
        chk_frame("bp0", 0, 8'hA3, da);
        chk_frame("bp1", 15, 8'hA6, db);

        q.delete();
        out_ready = 1'b1;
        strobe(8'h02, da);
        for (int c = 0; c < 50 && q.size() < 5; c++) begin
            @(posedge clock);
            #1;
        end
        chk("mid_bytes", 32'(q.size()), 32'd5);
        resetn = 1'b0;
        #1;
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_byte", 32'(out_byte), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        q.delete();
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        chk("mid_residual", 32'(q.size()), 32'd0);
        strobe(8'h20, db);
        wait_bytes(15, 1'b0);
        wait_idle();
        chk("post_len", 32'(q.size()), 32'd15);
        chk_frame("post", 0, 8'hA5, db);
        chk("post_drop", 32'(drop_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
